// File: rtl/sseg_scan_display.sv
// Sequential binary-to-BCD converter driving a four-digit multiplexed
// active-low seven-segment display with leading-zero blanking and sign.
module sseg_scan_display #(
    parameter int DATA_W      = 8,
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] value,
    input  logic              neg,
    input  logic              load,
    output logic              busy,
    output logic [0:6]        sseg,
    output logic [3:0]        an
);

    localparam int CW = $clog2(DATA_W + 1);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] MINUS = 7'b1111110;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        UPDATE
    } state_t;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = BLANK;
        endcase
        return s;
    endfunction

    state_t            state_q;
    logic [DATA_W-1:0] sh_q;
    logic [11:0]       bcd_q;
    logic [11:0]       bcd_adj;
    logic              neg_q;
    logic [CW-1:0]     it_q;
    logic              busy_q;
    logic [3:0][6:0]   disp_q;
    logic [3:0][6:0]   disp_new;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Digits above the most significant nonzero one are blanked.
    always_comb begin
        disp_new[0] = seg7(bcd_q[3:0]);
        disp_new[1] = (bcd_q[11:4] != 8'd0) ? seg7(bcd_q[7:4]) : BLANK;
        disp_new[2] = (bcd_q[11:8] != 4'd0) ? seg7(bcd_q[11:8]) : BLANK;
        disp_new[3] = neg_q ? MINUS : BLANK;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            it_q    <= '0;
            busy_q  <= 1'b0;
            disp_q  <= {4{BLANK}};
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load) begin
                        sh_q    <= value;
                        bcd_q   <= '0;
                        neg_q   <= neg;
                        it_q    <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    bcd_q <= {bcd_adj[10:0], sh_q[DATA_W-1]};
                    sh_q  <= sh_q << 1;
                    it_q  <= it_q + 1'b1;
                    if (it_q == CW'(DATA_W - 1)) begin
                        state_q <= UPDATE;
                    end
                end
                UPDATE: begin
                    disp_q  <= disp_new;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    logic [RW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic          on_q, on_d;
    logic          wrap;
    logic [3:0]    an_q;
    logic [6:0]    sseg_q;

    // Digits stay dark until the first refresh wrap after reset.
    always_comb begin
        wrap  = (cnt_q == RW'(REFRESH_DIV - 1));
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        on_d  = on_q | wrap;
        idx_d = (wrap && on_q) ? idx_q + 2'd1 : idx_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            on_q   <= 1'b0;
            an_q   <= 4'b1111;
            sseg_q <= BLANK;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            on_q   <= on_d;
            an_q   <= on_d ? ~(4'b0001 << idx_d) : 4'b1111;
            sseg_q <= on_d ? disp_q[idx_d] : BLANK;
        end
    end

    assign busy = busy_q;
    assign an   = an_q;
    assign sseg = sseg_q;

endmodule

// File: tb/tb_sseg_scan_display.sv
// Randomized bench for sseg_scan_display against a cycle-counting
// arithmetic model of conversion latency, blanking and digit scan.
module tb_sseg_scan_display;

    localparam int DW = 8;
    localparam int RD = 4;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] MI = 7'b1111110;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load = 1'b0;
    logic          neg = 1'b0;
    logic [DW-1:0] value = '0;
    logic          busy;
    logic [0:6]    sseg;
    logic [3:0]    an;

    always #5 clk = ~clk;

    sseg_scan_display #(
        .DATA_W     (DW),
        .REFRESH_DIV(RD)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .value(value),
        .neg  (neg),
        .load (load),
        .busy (busy),
        .sseg (sseg),
        .an   (an)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg(input int d);
        logic [6:0] s;
        case (d)
            0:       s = 7'b0000001;
            1:       s = 7'b1001111;
            2:       s = 7'b0010010;
            3:       s = 7'b0000110;
            4:       s = 7'b1001100;
            5:       s = 7'b0100100;
            6:       s = 7'b0100000;
            7:       s = 7'b0001111;
            8:       s = 7'b0000000;
            9:       s = 7'b0000100;
            default: s = BL;
        endcase
        return s;
    endfunction

    int         e = 0;
    int         rem = 0;
    bit         mbusy = 1'b0;
    logic [6:0] mdisp[4] = '{BL, BL, BL, BL};
    logic [6:0] mprev[4] = '{BL, BL, BL, BL};
    logic [6:0] mpend[4] = '{BL, BL, BL, BL};

    task automatic mk(input int v, input bit n);
        mpend[0] = seg(v % 10);
        mpend[1] = (v >= 10) ? seg((v / 10) % 10) : BL;
        mpend[2] = (v >= 100) ? seg(v / 100) : BL;
        mpend[3] = n ? MI : BL;
    endtask

    task automatic tick(input bit r, input bit ld, input int v,
                        input bit n);
        int         w;
        logic [3:0] ea;
        logic [6:0] es;
        rst   = r;
        load  = ld;
        value = v[DW-1:0];
        neg   = n;
        @(posedge clk);
        mprev = mdisp;
        if (!r) begin
            e     = 0;
            mbusy = 1'b0;
            rem   = 0;
            mdisp = '{BL, BL, BL, BL};
        end else begin
            e++;
            if (mbusy) begin
                rem--;
                if (rem == 0) begin
                    mbusy = 1'b0;
                    mdisp = mpend;
                end
            end else if (ld) begin
                mbusy = 1'b1;
                rem   = DW + 1;
                mk(v, n);
            end
        end
        #1;
        w = e / RD;
        if (w == 0) begin
            ea = 4'b1111;
            es = BL;
        end else begin
            ea = ~(4'b0001 << ((w - 1) % 4));
            es = mprev[(w - 1) % 4];
        end
        chk("busy", 32'(busy), 32'(mbusy));
        chk("an", 32'(an), 32'(ea));
        chk("sseg", 32'(sseg), 32'(es));
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) tick(1'b1, 1'b0, 0, 1'b0);
    endtask

    task automatic do_load(input int v, input bit n);
        tick(1'b1, 1'b1, v, n);
    endtask

    initial begin
        int bl;
        repeat (3) tick(1'b0, 1'b0, 0, 1'b0);
        idle(2 * RD + 3);

        do_load(0, 1'b0);
        idle(30);

        do_load(123, 1'b0);
        bl = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) bl++;
            tick(1'b1, 1'b0, 0, 1'b0);
        end
        chk("busy_len_123", 32'(bl), 32'(DW + 1));

        do_load(5, 1'b1);
        idle(25);
        do_load(255, 1'b0);
        idle(25);

        do_load(7, 1'b0);
        idle(3);
        do_load(9, 1'b0);
        idle(25);

        do_load(42, 1'b0);
        idle(25);
        do_load(200, 1'b0);
        idle(4);
        tick(1'b0, 1'b0, 0, 1'b0);
        idle(2 * RD);
        do_load(200, 1'b0);
        idle(25);

        for (int i = 0; i < 60; i++) begin
            int gap;
            if ($urandom_range(0, 29) == 0) begin
                tick(1'b0, 1'b0, 0, 1'b0);
            end
            do_load(int'($urandom_range(0, 255)), bit'($urandom_range(0, 1)));
            gap = int'($urandom_range(0, 24));
            for (int j = 0; j < gap; j++) begin
                tick(1'b1, bit'($urandom_range(0, 3) == 0),
                     int'($urandom_range(0, 255)),
                     bit'($urandom_range(0, 1)));
            end
        end
        idle(25);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
